// File: rtl/cpu_pkg.sv
// Types and constants shared by the CPU pipeline stages.
package cpu_pkg;

    localparam int WORD_W     = 32;
    localparam int INST_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/adder.sv
// Plain modular adder; the fetch stage uses it for pc + 4.
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one outstanding word read at a time
// and buffers {pc, inst} pairs in a 2-entry queue for decode.
//
// state | meaning
// IDLE  | no request outstanding; issue when the queue has room
// REQ   | request outstanding at imem_addr; response is pushed on ack
// DRAIN | request outstanding but redirected; response dropped, then jump to pending
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int               WIDTH    = WORD_W,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_data,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc
);

    fetch_state_t     state, state_nxt;
    logic [WIDTH-1:0] pc, pc_nxt, pc_inc;
    logic [WIDTH-1:0] pending, pending_nxt;
    logic [WIDTH-1:0] target;
    logic             req_nxt;
    logic [WIDTH-1:0] addr_nxt;

    logic [WIDTH-1:0] q_inst [2];
    logic [WIDTH-1:0] q_pc   [2];
    logic             wr_ptr, rd_ptr;
    logic [1:0]       count, count_after, count_nxt;
    logic             push, pop, flush;

    adder #(.WIDTH(WIDTH)) u_pc_adder (
        .a   (pc),
        .b   (WIDTH'(INST_BYTES)),
        .sum (pc_inc)
    );

    assign target      = redirect_pc & ~WIDTH'(3);
    assign pop         = inst_valid & inst_ready;
    assign count_after = count - {1'b0, pop};
    assign inst        = q_inst[rd_ptr];
    assign inst_pc     = q_pc[rd_ptr];

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        pending_nxt = pending;
        req_nxt     = imem_req;
        addr_nxt    = imem_addr;
        push        = 1'b0;
        flush       = 1'b0;
        case (state)
            IDLE: begin
                if (redirect_valid) begin
                    pc_nxt = target;
                    flush  = 1'b1;
                end else if (count_after != 2'd2) begin
                    state_nxt = REQ;
                    req_nxt   = 1'b1;
                    addr_nxt  = pc;
                end
            end
            REQ: begin
                if (imem_ack && redirect_valid) begin
                    flush     = 1'b1;
                    pc_nxt    = target;
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                end else if (imem_ack) begin
                    push   = 1'b1;
                    pc_nxt = pc_inc;
                    // count never exceeds 1 here, so room after the push means empty now
                    if (count_after == 2'd0) begin
                        addr_nxt = pc_inc;
                    end else begin
                        state_nxt = IDLE;
                        req_nxt   = 1'b0;
                    end
                end else if (redirect_valid) begin
                    flush       = 1'b1;
                    pending_nxt = target;
                    state_nxt   = DRAIN;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    flush       = 1'b1;
                    pending_nxt = target;
                end
                if (imem_ack) begin
                    pc_nxt    = redirect_valid ? target : pending;
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                req_nxt   = 1'b0;
            end
        endcase
        count_nxt = flush ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            pending    <= '0;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            inst_valid <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                q_inst[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pending    <= pending_nxt;
            imem_req   <= req_nxt;
            imem_addr  <= addr_nxt;
            count      <= count_nxt;
            inst_valid <= (count_nxt != 2'd0);
            if (flush) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) begin
                    q_inst[wr_ptr] <= imem_data;
                    q_pc[wr_ptr]   <= pc;
                    wr_ptr         <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
            end
        end
    end

endmodule
